// File: rtl/mem_sys_pkg.sv
// ------------------------------------------------------------------
// mem_sys_pkg: shared types for the system-side memory requester
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_sys_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_fifo.sv
// ------------------------------------------------------------------
// mem_cmd_fifo: command FIFO with wrap-around pointers (extra MSB)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_cmd_fifo
  import mem_sys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  mem_cmd_t                     push_data,
  input  logic                         pop,
  output mem_cmd_t                     pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  mem_cmd_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Full when the index bits match but the wrap bits differ.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = CW'(wr_ptr - rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mem_sys_requester.sv
// ------------------------------------------------------------------
// mem_sys_requester: queues host requests, issues them one at a time
// on the system bus and returns one response per command. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_sys_requester
  import mem_sys_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        we_sys,
  output logic                        cmd_valid_sys,
  output logic [ADDR_W-1:0]           addr_sys,
  input  logic                        ready_sys,
  inout  wire  [DATA_W-1:0]           data_sys
);

  localparam int            TMR_W    = 8;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  state_e     state;
  state_e     next_state;
  mem_cmd_t   cmd;
  mem_cmd_t   fifo_head;
  logic [TMR_W-1:0] timer;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       done;
  logic       expire;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  mem_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{we: req_we, addr: req_addr, data: req_wdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Completion is tested before expiry so a ready on the last cycle wins.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done       = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (ready_sys) begin
          done       = 1'b1;
          next_state = IDLE;
        end else if (timer == TMO_LAST) begin
          expire     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd       <= '0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done || expire;
      rsp_err   <= expire;
      rsp_rdata <= (done && !cmd.we) ? data_sys : '0;
      if (pop) begin
        cmd   <= fifo_head;
        timer <= '0;
      end else if (state == ISSUE) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  assign cmd_valid_sys = (state == ISSUE);
  assign we_sys        = cmd.we;
  assign addr_sys      = cmd.addr;
  assign data_sys      = (state == ISSUE && cmd.we) ? cmd.data : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mem_sys_requester.sv
// ------------------------------------------------------------------
// tb_mem_sys_requester: schedule-based reference model + bus controller
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_sys_requester;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] count;
  logic       we_sys, cmd_valid_sys, ready_sys;
  logic [7:0] addr_sys;
  wire  [7:0] data_sys;
  logic       tb_drv;
  logic [7:0] tb_val;

  assign data_sys = tb_drv ? tb_val : 8'hzz;

  mem_sys_requester #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .count(count), .we_sys(we_sys), .cmd_valid_sys(cmd_valid_sys),
    .addr_sys(addr_sys), .ready_sys(ready_sys), .data_sys(data_sys)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] data; int p; } req_t;
  typedef struct { int rise; int at; logic err; logic [7:0] rdata; } rsp_rec_t;

  // Model: each command issues one cycle after max(push edge, previous end edge)
  // and ends after wait+1 cycles, or after TMO cycles when it times out.
  req_t       offer_q[$];
  req_t       pend[$];
  int         wait_q[$];
  req_t       cur;
  bit         cur_act, cur_err;
  int         cur_s, cur_e, cur_w, last_e, cyc, p_valid;
  logic [7:0] mem_m [256];

  bit         chk_en, exp_rsp, exp_err, exp_cv, exp_we, exp_rr;
  logic [7:0] exp_rdata, exp_addr, exp_bus;
  logic [2:0] exp_count;

  rsp_rec_t   rlog[$];
  int         last_rise;
  logic       prev_cv;
  int         n_vec, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_exp();
    exp_count = 3'(pend.size());
    exp_rr    = pend.size() < DEPTH;
    exp_cv    = cur_act;
    exp_we    = cur.we;
    exp_addr  = cur.addr;
  endtask

  task automatic model_reset();
    pend.delete(); offer_q.delete(); wait_q.delete();
    cur_act = 0; cur = '{0, 8'h0, 8'h0, 0}; last_e = -100;
    exp_rsp = 0; prev_cv = 0;
    set_exp();
  endtask

  task automatic model_edge();
    int cnt_before, start, w;
    cnt_before = pend.size();
    exp_rsp = 0;
    if (cur_act && cyc == cur_e) begin
      exp_rsp   = 1;
      exp_err   = cur_err;
      exp_rdata = (cur_err || cur.we) ? 8'h00 : mem_m[cur.addr];
      if (!cur_err && cur.we) mem_m[cur.addr] = cur.data;
      cur_act = 0;
      last_e  = cyc;
    end
    if (!cur_act && pend.size() > 0) begin
      start = ((pend[0].p > last_e) ? pend[0].p : last_e) + 1;
      if (cyc >= start) begin
        cur = pend.pop_front();
        cur_act = 1;
        cur_s = cyc;
        if (wait_q.size() > 0) w = wait_q.pop_front();
        else begin
          int r = int'($urandom_range(99));
          w = (r < 70) ? int'($urandom_range(4)) : (r < 85) ? TMO - 1 : TMO;
        end
        cur_w   = w;
        cur_err = (w >= TMO);
        cur_e   = cur_err ? cyc + TMO : cyc + 1 + w;
      end
    end
    if (req_valid && cnt_before < DEPTH) begin
      pend.push_back('{req_we, req_addr, req_wdata, cyc});
      void'(offer_q.pop_front());
    end
    set_exp();
  endtask

  task automatic drive_inputs();
    if (cur_act) ready_sys = !cur_err && (cyc == cur_s + cur_w);
    else         ready_sys = 1'($urandom_range(1));
    if (cur_act && cur.we) begin
      tb_drv = 0; exp_bus = cur.data;
    end else begin
      tb_drv = 1; tb_val = cur_act ? mem_m[cur.addr] : 8'($urandom); exp_bus = tb_val;
    end
    if (offer_q.size() > 0 && int'($urandom_range(99)) < p_valid) begin
      req_valid = 1; req_we = offer_q[0].we; req_addr = offer_q[0].addr; req_wdata = offer_q[0].data;
    end else begin
      req_valid = 0; req_we = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    drive_inputs();
  endtask

  task automatic run_quiet(input int budget);
    int n = 0;
    while ((offer_q.size() > 0 || pend.size() > 0 || cur_act) && n < budget) begin
      step(); n++;
    end
    chk("drain_budget", 32'(offer_q.size() + pend.size() + int'(cur_act)), 32'd0);
    step(); step();
  endtask

  task automatic offer(input logic we, input logic [7:0] a, input logic [7:0] d);
    offer_q.push_back('{we, a, d, 0});
  endtask

  task automatic chk_rsp(input string nm, input int idx, input int lat, input logic err, input logic [7:0] rd);
    if (rlog.size() <= idx) chk({nm, "_present"}, 32'(rlog.size()), 32'(idx + 1));
    else begin
      chk({nm, "_lat"},   32'(rlog[idx].at - rlog[idx].rise), 32'(lat));
      chk({nm, "_err"},   32'(rlog[idx].err), 32'(err));
      chk({nm, "_rdata"}, 32'(rlog[idx].rdata), 32'(rd));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(exp_count));
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("cmd_valid_sys", 32'(cmd_valid_sys), 32'(exp_cv));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      end
      if (exp_cv) begin
        chk("we_sys", 32'(we_sys), 32'(exp_we));
        chk("addr_sys", 32'(addr_sys), 32'(exp_addr));
      end
      chk("data_sys", 32'(data_sys), 32'(exp_bus));
      if (cmd_valid_sys && !prev_cv) last_rise = cyc;
      prev_cv = cmd_valid_sys;
      if (rsp_valid) rlog.push_back('{last_rise, cyc, rsp_err, rsp_rdata});
    end
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; chk_en = 0; p_valid = 100; last_rise = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i) ^ 8'h5A;
    reset = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    ready_sys = 0; tb_drv = 1; tb_val = 8'h5A;
    model_reset();
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_we_sys", 32'(we_sys), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid_sys), 32'd0);
    chk("rst_addr_sys", 32'(addr_sys), 32'd0);
    chk("rst_data_sys", 32'(data_sys), 32'h5A);
    @(negedge clk); reset = 1; exp_bus = tb_val; chk_en = 1;

    // Single write, ready two cycles after cmd_valid rises.
    rlog.delete(); offer(1, 8'h10, 8'hA5); wait_q.push_back(2); run_quiet(200);
    chk_rsp("wr", 0, 3, 1'b0, 8'h00);

    // Read back from the controller.
    rlog.delete(); offer(0, 8'h10, 8'h00); wait_q.push_back(0); run_quiet(200);
    chk_rsp("rd", 0, 1, 1'b0, 8'hA5);

    // Five requests into a four-deep FIFO while the first one waits.
    rlog.delete();
    offer(1, 8'h20, 8'h11); offer(0, 8'h20, 8'h00); offer(1, 8'h21, 8'h22);
    offer(0, 8'h21, 8'h00); offer(1, 8'h22, 8'h33);
    wait_q = '{6, 3, 0, 1, 2};
    for (int n = 0; n < 50 && offer_q.size() > 0; n++) step();
    @(negedge clk); #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    run_quiet(300);
    chk("full_nrsp", 32'(rlog.size()), 32'd5);
    chk_rsp("full_rd1", 1, 4, 1'b0, 8'h11);

    // Timeout, then the next queued command proceeds.
    rlog.delete(); offer(1, 8'h30, 8'h77); offer(0, 8'h30, 8'h00);
    wait_q = '{TMO, 0}; run_quiet(300);
    chk_rsp("tmo", 0, 8, 1'b1, 8'h00);
    chk_rsp("after_tmo", 1, 1, 1'b0, 8'h6A);
    if (rlog.size() > 1) chk("after_tmo_gap", 32'(rlog[1].rise - rlog[0].at), 32'd1);

    // Ready on the expiry cycle completes normally.
    rlog.delete(); offer(0, 8'h10, 8'h00); wait_q.push_back(TMO - 1); run_quiet(300);
    chk_rsp("tmo_edge", 0, 8, 1'b0, 8'hA5);

    // Reset while a write is on the bus with three entries queued.
    offer(1, 8'h40, 8'hC3); offer(1, 8'h41, 8'hC3); offer(1, 8'h42, 8'hC3); offer(1, 8'h43, 8'hC3);
    wait_q = '{TMO, TMO, TMO, TMO};
    for (int n = 0; n < 50 && offer_q.size() > 0; n++) step();
    @(negedge clk); #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    #1;
    chk_en = 0; reset = 0; tb_drv = 1; tb_val = 8'h3C; req_valid = 0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_cmd_valid", 32'(cmd_valid_sys), 32'd0);
    chk("mid_rst_data_sys", 32'(data_sys), 32'h3C);
    model_reset();
    step(); step();
    @(negedge clk); reset = 1; rlog.delete(); chk_en = 1;
    for (int n = 0; n < 20; n++) step();
    chk("post_rst_nrsp", 32'(rlog.size()), 32'd0);

    // Randomized traffic.
    p_valid = 40;
    for (int n = 0; n < 1500; n++) begin
      if (offer_q.size() == 0) offer(1'($urandom), 8'($urandom_range(15)), 8'($urandom));
      step();
    end
    run_quiet(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
